// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: turns a 16x128 single-port SRAM with registered read data into a 128-deep FIFO.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   wr_valid/wr_data/wr_ready   push interface
//   rd_valid/rd_data/rd_ready   pop interface (rd_data is a one-word output slot)
//   count/full/empty    words held in SRAM not yet launched for read; status flags
//   mem_inbits/mem_addr/mem_we/mem_re   registered SRAM controls
//   mem_outbits         SRAM registered read data
module sram_fifo_ctrl #(
    parameter int DW = 16,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          rd_ready,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] mem_inbits,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_outbits
);
    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DATA} state_t;

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          mem_we_q, mem_we_d, mem_re_q, mem_re_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_inbits_q, mem_inbits_d;
    logic          launch, push;

    // A read launches only when the output slot will be free by the time data returns;
    // it wins the single SRAM port over a push at the same edge.
    assign launch   = (state_q == IDLE) & (count_q != '0) & (!rd_valid_q | rd_ready);
    assign full     = count_q == DEPTH;
    assign wr_ready = !full & !launch;
    assign push     = wr_valid & wr_ready;
    assign empty    = (count_q == '0) & (state_q == IDLE) & !rd_valid_q;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_valid_d   = rd_valid_q;
        rd_data_d    = rd_data_q;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        mem_addr_d   = '0;
        mem_inbits_d = '0;
        state_d      = (state_q == IDLE) ? (launch ? RD_ISSUE : IDLE) :
                       (state_q == RD_ISSUE) ? RD_DATA : IDLE;
        count_d      = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, launch};
        wr_ptr_d     = wr_ptr_q + AW'(push);
        rd_ptr_d     = rd_ptr_q + AW'(launch);
        // A capture in RD_DATA refills the slot even if it is being popped at this edge.
        rd_valid_d   = (state_q == RD_DATA) | (rd_valid_q & !rd_ready);
        rd_data_d    = (state_q == RD_DATA) ? mem_outbits : rd_data_q;
        mem_we_d     = push;
        mem_re_d     = launch;
        mem_addr_d   = launch ? rd_ptr_q : push ? wr_ptr_q : '0;
        mem_inbits_d = push ? wr_data : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_inbits_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            mem_addr_q   <= mem_addr_d;
            mem_inbits_q <= mem_inbits_d;
        end
    end

    assign count      = count_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign mem_we     = mem_we_q;
    assign mem_re     = mem_re_q;
    assign mem_addr   = mem_addr_q;
    assign mem_inbits = mem_inbits_q;
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed vectors plus scoreboard sequences for sram_fifo_ctrl with a behavioural SRAM.
module tb_sram_fifo_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = '0;
    logic        wr_ready;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_ready = 1'b0;
    logic [7:0]  count;
    logic        full, empty;
    logic [15:0] mem_inbits, mem_outbits;
    logic [6:0]  mem_addr;
    logic        mem_we, mem_re;

    sram_fifo_ctrl dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .count(count), .full(full), .empty(empty),
        .mem_inbits(mem_inbits), .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_outbits(mem_outbits)
    );

    always #5 clk = ~clk;

    // SRAM model: registered read, re has priority, outbits held on write-only cycles.
    logic [15:0] mem [128];
    logic [15:0] outbits_q = '0;
    always_ff @(posedge clk) begin
        if (mem_re) outbits_q <= mem[mem_addr];
        else if (mem_we) mem[mem_addr] <= mem_inbits;
    end
    assign mem_outbits = outbits_q;

    typedef struct {
        logic        wv;
        logic [15:0] wd;
        logic        rr;
        logic [7:0]  cnt;
        logic        rv;
        logic [15:0] rd;
        logic        emp, ful, we, re;
        logic [6:0]  addr;
        logic [15:0] inb;
    } vec_t;

    vec_t        vec [15];
    int          tests = 0;
    int          fails = 0;
    int          conflict = 0;
    bit          sb_en = 0;
    logic [15:0] sbq [$];
    logic        a, p;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs at negedge, then sample handshakes mid-cycle.
    task automatic cyc(input logic wv, input logic [15:0] d, input logic rr, output logic acc, output logic pop);
        @(negedge clk);
        wr_valid = wv;
        wr_data  = d;
        rd_ready = rr;
        #1;
        acc = wv & wr_ready;
        pop = rd_valid & rr;
        if (mem_we & mem_re) conflict++;
        if (sb_en && pop) begin
            if (sbq.size() == 0) chk("pop_unexpected", 64'(rd_data), 64'hFFFF_FFFF);
            else chk("pop_order", 64'(rd_data), 64'(sbq.pop_front()));
        end
        if (sb_en && acc) sbq.push_back(d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc_n, pops, lat;
        vec[0]  = '{1'b0, 16'h0000, 1'b1, 8'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0000};
        vec[1]  = '{1'b1, 16'hA5A5, 1'b1, 8'd1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 16'hA5A5};
        vec[2]  = '{1'b0, 16'h0000, 1'b1, 8'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 16'h0000};
        vec[3]  = '{1'b0, 16'h0000, 1'b1, 8'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0000};
        vec[4]  = '{1'b0, 16'h0000, 1'b0, 8'd0, 1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0000};
        vec[5]  = '{1'b0, 16'h0000, 1'b1, 8'd0, 1'b0, 16'hA5A5, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0000};
        vec[6]  = '{1'b1, 16'h1111, 1'b0, 8'd1, 1'b0, 16'hA5A5, 1'b0, 1'b0, 1'b1, 1'b0, 7'd1, 16'h1111};
        vec[7]  = '{1'b1, 16'h2222, 1'b0, 8'd0, 1'b0, 16'hA5A5, 1'b0, 1'b0, 1'b0, 1'b1, 7'd1, 16'h0000};
        vec[8]  = '{1'b1, 16'h2222, 1'b0, 8'd1, 1'b0, 16'hA5A5, 1'b0, 1'b0, 1'b1, 1'b0, 7'd2, 16'h2222};
        vec[9]  = '{1'b0, 16'h0000, 1'b0, 8'd1, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0000};
        vec[10] = '{1'b0, 16'h0000, 1'b0, 8'd1, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0000};
        vec[11] = '{1'b0, 16'h0000, 1'b1, 8'd0, 1'b0, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1, 7'd2, 16'h0000};
        vec[12] = '{1'b0, 16'h0000, 1'b0, 8'd0, 1'b0, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0000};
        vec[13] = '{1'b0, 16'h0000, 1'b1, 8'd0, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0000};
        vec[14] = '{1'b0, 16'h0000, 1'b1, 8'd0, 1'b0, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0000};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_flags", 64'({empty, full, wr_ready, rd_valid, mem_we, mem_re}), 64'b101000);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            cyc(vec[i].wv, vec[i].wd, vec[i].rr, a, p);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i),
                64'({count, rd_valid, rd_data, empty, full, mem_we, mem_re, mem_addr, mem_inbits}),
                64'({vec[i].cnt, vec[i].rv, vec[i].rd, vec[i].emp, vec[i].ful, vec[i].we, vec[i].re, vec[i].addr, vec[i].inb}));
        end

        // Fill with the consumer stalled: 128 in SRAM plus one in the output slot.
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        sb_en = 1;
        conflict = 0;
        acc_n = 0;
        for (int k = 0; k < 1000 && acc_n < 129; k++) begin
            cyc(1'b1, 16'(acc_n), 1'b0, a, p);
            if (a) acc_n++;
        end
        chk("fill_accepted", 64'(acc_n), 64'd129);
        @(posedge clk);
        #1;
        chk("full_count", 64'(count), 64'd128);
        chk("full_flags", 64'({full, wr_ready, empty, rd_valid}), 64'b1001);
        cyc(1'b1, 16'hDEAD, 1'b0, a, p);
        chk("overflow_reject", 64'(a), 64'd0);
        @(posedge clk);
        #1;
        chk("overflow_count", 64'(count), 64'd128);

        pops = 0;
        for (int k = 0; k < 1000 && pops < 129; k++) begin
            cyc(1'b0, 16'h0000, 1'b1, a, p);
            if (p) pops++;
        end
        chk("drain_pops", 64'(pops), 64'd129);
        @(posedge clk);
        #1;
        chk("drain_empty", 64'({empty, count}), 64'({1'b1, 8'd0}));

        // Pointers now sit at 1; keep pushing and popping across the wrap.
        acc_n = 0;
        pops = 0;
        for (int k = 0; k < 5000 && pops < 200; k++) begin
            cyc(acc_n < 200, 16'h1000 + 16'(acc_n), 1'b1, a, p);
            if (a) acc_n++;
            if (p) pops++;
        end
        chk("wrap_pops", 64'(pops), 64'd200);
        chk("wrap_sb_left", 64'(sbq.size()), 64'd0);
        chk("we_re_conflicts", 64'(conflict), 64'd0);

        // Reset while the launched word is in RD_DATA.
        sb_en = 0;
        cyc(1'b1, 16'hBEEF, 1'b1, a, p);
        cyc(1'b0, 16'h0000, 1'b1, a, p);
        cyc(1'b0, 16'h0000, 1'b1, a, p);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_state", 64'({rd_valid, empty, mem_re, mem_we, count}), 64'({4'b0100, 8'd0}));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_after", 64'({rd_valid, empty}), 64'b01);
        sbq.delete();
        sb_en = 1;
        cyc(1'b1, 16'h1234, 1'b1, a, p);
        chk("post_rst_push", 64'(a), 64'd1);
        lat = 0;
        p = 1'b0;
        for (int k = 0; k < 20 && !p; k++) begin
            cyc(1'b0, 16'h0000, 1'b1, a, p);
            lat++;
        end
        chk("post_rst_pop_seen", 64'(p), 64'd1);
        chk("post_rst_latency", 64'(lat), 64'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
